// File: rtl/alu_wb_stage.sv
// ---------------------------------------------------------------------------
// alu_wb_stage
//
// Purpose:
//   Writeback stage behind the ALU. ALU results are queued in a 2-entry
//   in-order FIFO. Each result is either written to the register file
//   through a valid/ready write port, or it is dropped when it has no
//   register target or targets XZR (rd = 31). Every entry that leaves
//   the FIFO retires one instruction. If the instruction sets flags, the
//   architectural NZCV flags are also loaded at that point. A synchronous
//   flush empties the FIFO without retiring anything.
//
// Optional feature (macro WB_FWD_EN):
//   When defined, a forwarding query port reports whether a pending write
//   targets fwd_addr and returns the youngest such result.
//   When undefined, the fwd_* ports and their logic do not exist.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   in_valid/in_ready  ALU result handshake (in_ready = occupancy < 2)
//   in_rd, in_result   destination register and result
//   in_z/n/c/v         ALU flags
//   in_wr_en           result targets a register
//   in_set_flags       instruction updates NZCV
//   flush              synchronous pipeline flush
//   wb_valid/wb_ready  register-file write handshake
//   wb_rd, wb_data     write address / data (head of FIFO)
//   nzcv               architectural flags {N,Z,C,V}
//   retired            16-bit wrapping retired-instruction counter
//   fwd_addr/hit/data  forwarding query (WB_FWD_EN only)
// ---------------------------------------------------------------------------
module alu_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic        in_z,
    input  logic        in_n,
    input  logic        in_c,
    input  logic        in_v,
    input  logic        in_wr_en,
    input  logic        in_set_flags,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  nzcv,
    output logic [15:0] retired
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);

    // FIFO storage: two slots addressed circularly by head_q / count_q
    logic [4:0]  rd_q   [2];
    logic [4:0]  rd_d   [2];
    logic [31:0] res_q  [2];
    logic [31:0] res_d  [2];
    logic [3:0]  flg_q  [2];   // {n,z,c,v}
    logic [3:0]  flg_d  [2];
    logic        wr_q   [2];
    logic        wr_d   [2];
    logic        sf_q   [2];
    logic        sf_d   [2];

    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  nzcv_q, nzcv_d;
    logic [15:0] retired_q, retired_d;

    logic        non_empty;
    logic        head_writes;
    logic        push;
    logic        pop;
    logic        tail;

    always_comb begin
        non_empty   = (count_q != 2'd0);
        // XZR writes are discarded: such entries never reach the write port
        head_writes = non_empty && wr_q[head_q] && (rd_q[head_q] != 5'd31);
        in_ready    = (count_q != 2'd2);
        push        = !flush && in_valid && in_ready;
        // Non-writing heads drain on their own; writing heads wait for the port
        pop         = !flush && non_empty && (!head_writes || wb_ready);
        // With count 0 the tail is the head slot, with count 1 it is the other one
        tail        = head_q ^ count_q[0];

        rd_d      = rd_q;
        res_d     = res_q;
        flg_d     = flg_q;
        wr_d      = wr_q;
        sf_d      = sf_q;
        head_d    = head_q;
        count_d   = count_q;
        nzcv_d    = nzcv_q;
        retired_d = retired_q;

        if (push) begin
            rd_d[tail]  = in_rd;
            res_d[tail] = in_result;
            flg_d[tail] = {in_n, in_z, in_c, in_v};
            wr_d[tail]  = in_wr_en;
            sf_d[tail]  = in_set_flags;
        end

        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            head_d  = head_q ^ pop;
        end

        if (pop) begin
            retired_d = retired_q + 16'd1;
            if (sf_q[head_q]) begin
                nzcv_d = flg_q[head_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rd_q[i]  <= '0;
                res_q[i] <= '0;
                flg_q[i] <= '0;
                wr_q[i]  <= 1'b0;
                sf_q[i]  <= 1'b0;
            end
            head_q    <= 1'b0;
            count_q   <= 2'd0;
            nzcv_q    <= 4'b0000;
            retired_q <= 16'h0000;
        end else begin
            rd_q      <= rd_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
            wr_q      <= wr_d;
            sf_q      <= sf_d;
            head_q    <= head_d;
            count_q   <= count_d;
            nzcv_q    <= nzcv_d;
            retired_q <= retired_d;
        end
    end

    // Flush masks the write request in the same cycle it is asserted
    assign wb_valid = head_writes && !flush;
    assign wb_rd    = non_empty ? rd_q[head_q]  : 5'd0;
    assign wb_data  = non_empty ? res_q[head_q] : 32'd0;
    assign nzcv     = nzcv_q;
    assign retired  = retired_q;

`ifdef WB_FWD_EN
    logic [1:0] slot_match;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic slot_valid;
            assign slot_valid = (count_q == 2'd2) ||
                                ((count_q == 2'd1) && (head_q == 1'(gi)));
            assign slot_match[gi] = slot_valid && wr_q[gi] &&
                                    (rd_q[gi] != 5'd31) && (rd_q[gi] == fwd_addr);
        end
    endgenerate

    // The slot after the head is the younger one whenever both slots are valid
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        if (slot_match[~head_q]) begin
            fwd_hit  = 1'b1;
            fwd_data = res_q[~head_q];
        end else if (slot_match[head_q]) begin
            fwd_hit  = 1'b1;
            fwd_data = res_q[head_q];
        end
    end
`endif

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have ports (name direction width meaning), in this order:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept.
- in_rd  in  5  destination register.
- in_result  in  32  ALU result.
- in_z / in_n / in_c / in_v  in  1 each  ALU flags.
- in_wr_en  in  1  result targets a register.
- in_set_flags  in  1  instruction updates NZCV.
- flush  in  1  synchronous pipeline flush.
- wb_valid  out  1  register-file write request.
- wb_ready  in  1  write port granted.
- wb_rd  out  5  write address.
- wb_data  out  32  write data.
- nzcv  out  4  architectural flags {N,Z,C,V}.
- retired  out  16  retired-instruction counter.
- fwd_addr  in  5  forwarding query register (only with WB_FWD_EN).
- fwd_hit  out  1  query matches a pending write (only with WB_FWD_EN).
- fwd_data  out  32  forwarded value (only with WB_FWD_EN).
REQ-002 SHALL have one clock, clk; reset rst_n asynchronous, active-low.

Function
REQ-003 SHALL hold a 2-entry in-order FIFO of {rd, result, flags, wr_en, set_flags}.
REQ-004 in_ready SHALL be 1 iff occupancy < 2 (registered occupancy; no pass-through when full).
REQ-005 Push occurs on in_valid && in_ready; an entry pushed in cycle N is visible at head no earlier than cycle N+1 (min latency 1).
REQ-006 Head "writes" iff wr_en=1 and rd!=31; rd=31 (XZR) results are discarded, never presented on wb.
REQ-007 wb_valid SHALL be 1 iff FIFO non-empty and head writes; wb_rd/wb_data = head fields; stable while wb_valid && !wb_ready.
REQ-008 Head pops when (head writes && wb_ready) or (non-empty && head does not write); at most one pop per cycle.
REQ-009 On pop with set_flags=1, nzcv SHALL load the head's {n,z,c,v} at that edge; otherwise nzcv holds.
REQ-010 On every pop, retired SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-011 Simultaneous push and pop SHALL be legal at any occupancy where in_ready=1; occupancy unchanged.
REQ-012 flush=1 SHALL empty the FIFO at that edge, drop any push in that cycle, suppress pop side-effects (no nzcv or retired update in that cycle), and force wb_valid=0 from the next cycle.
REQ-013 nzcv and retired SHALL NOT be altered by flush.
REQ-014 wb_valid SHALL be 0 in the same cycle flush is asserted (combinational mask).

Reset
REQ-015 rst_n low SHALL asynchronously clear FIFO (occupancy 0), nzcv=4'b0000, retired=16'h0000.
REQ-016 During and after reset: wb_valid=0, in_ready=1, wb_rd=0, wb_data=0, fwd_hit=0.
REQ-017 Reset asserted mid-transaction SHALL discard all pending entries with no nzcv/retired update.

Configuration
REQ-018 Macro WB_FWD_EN: when defined, fwd_addr/fwd_hit/fwd_data exist; fwd_hit=1 iff some valid entry writes (REQ-006) with rd==fwd_addr, fwd_data = youngest such entry's result, else fwd_data=0; combinational from fwd_addr and state.
REQ-019 Without WB_FWD_EN: fwd ports and logic absent; all other behaviour identical.

Verification
REQ-020 Push rd=1, result=0x0000_0005, set_flags=1, flags n=0 z=0 c=1 v=0, wb_ready=1 -> wb_valid next cycle with wb_rd=1, wb_data=5; after pop nzcv=4'b0010, retired=1.
REQ-021 wb_ready=0, push three results back-to-back -> in_ready drops after 2nd accept; 3rd held; raise wb_ready -> writes appear in order, retired=3.
REQ-022 Push rd=31, wr_en=1, set_flags=1, flags z=1 -> no wb_valid; entry pops next cycle; nzcv=4'b0100, retired increments.
REQ-023 Two pending entries, flush=1 same cycle as new push -> FIFO empty, push dropped, nzcv and retired unchanged, in_ready=1.
REQ-024 WB_FWD_EN: entries rd=4 result=0x11 then rd=4 result=0x22 pending, fwd_addr=4 -> fwd_hit=1, fwd_data=0x22; fwd_addr=31 -> fwd_hit=0.
REQ-025 Drive retired to 0xFFFF via pops, one more pop -> retired=0x0000; assert rst_n low mid-stall -> all outputs at reset values immediately.
